// File: rtl/cdc_event_arbiter.sv
// Round-robin arbiter that forwards one requester's payload per event into a toggle-flag crossing.
// Optional WAIT timeout with error pulse: define CDC_EVENT_ARBITER_TIMEOUT_EN.
module cdc_event_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            request,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] request_data,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            error,
  output logic [$clog2(NUM_REQ)-1:0]    grant_index,
  output logic                          busy,
  output logic                          flag_out,
  output logic [DATA_WIDTH-1:0]         data_out,
  input  logic                          ack_in
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          any_req;
  int            idx;

  // first requester at or after last_grant+1, wrapping at NUM_REQ
  always_comb begin
    any_req = 1'b0;
    win     = last_grant;
    idx     = 0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last_grant) + i) % NUM_REQ;
      cand = IW'(idx);
      if (!any_req && request[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign error = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      done        <= '0;
      flag_out    <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
      grant_index <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
      error       <= '0;
      wait_cnt    <= '0;
`endif
    end else begin
      flag_out <= 1'b0;
      done     <= '0;
`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
      error    <= '0;
`endif
      case (state)
        IDLE: if (any_req) begin
          state       <= SEND;
          busy        <= 1'b1;
          flag_out    <= 1'b1;
          grant_index <= win;
          last_grant  <= win;
          data_out    <= request_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
        SEND: begin
          state <= WAIT;
`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          // ack takes priority over a timeout landing in the same cycle
          if (ack_in) begin
            state             <= DONE;
            done[grant_index] <= 1'b1;
          end
`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state              <= DONE;
            error[grant_index] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_event_arbiter.sv
// Directed self-checking bench for cdc_event_arbiter; outputs sampled 1ns after each rising edge.
module tb_cdc_event_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int TMO     = 10;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ*DW-1:0] request_data;
  logic [NUM_REQ-1:0] done, error;
  logic [1:0]        grant_index;
  logic              busy, flag_out, ack_in;
  logic [DW-1:0]     data_out;

  int tests = 0;
  int fails = 0;

  cdc_event_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .request(request), .request_data(request_data),
    .done(done), .error(error), .grant_index(grant_index), .busy(busy),
    .flag_out(flag_out), .data_out(data_out), .ack_in(ack_in)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " flag"}, flag_out, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " error"}, error, 0);
    chk({tag, " data"}, data_out, 0);
    chk({tag, " grant"}, grant_index, 0);
  endtask

  logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    reset_n = 1'b0; request = '0; request_data = '0; ack_in = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    reset_n = 1'b1;

    // single requester, payload A5, ack after 5 cycles
    request = 4'b0001; request_data = 32'h000000A5;
    tick();
    chk("t1 flag", flag_out, 1);
    chk("t1 data", data_out, 8'hA5);
    chk("t1 grant", grant_index, 0);
    chk("t1 busy", busy, 1);
    tick();
    chk("t1 flag one cycle", flag_out, 0);
    tick(); tick(); tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t1 done", done, 4'b0001);
    chk("t1 busy in done", busy, 1);
    chk("t1 data stable", data_out, 8'hA5);
    request = 4'b0000;
    tick();
    chk("t1 busy low", busy, 0);
    chk("t1 done cleared", done, 0);

    // all requesting after a fresh reset: 0,1,2,3,0
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    request = 4'b1111; request_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2 flag", flag_out, 1);
      chk("t2 grant", grant_index, exp_seq[k]);
      chk("t2 data", data_out, 8'h11 * (exp_seq[k] + 1));
      tick();
      chk("t2 wait flag", flag_out, 0);
      tick(); tick();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      chk("t2 done", done, 4'b0001 << exp_seq[k]);
      if (k == 4) request = 4'b0000;
      tick();
      chk("t2 idle busy", busy, 0);
      chk("t2 idle flag", flag_out, 0);
    end

    // ack in IDLE, SEND and DONE is ignored
    ack_in = 1'b1;
    tick();
    chk("t3 idle ack busy", busy, 0);
    chk("t3 idle ack done", done, 0);
    ack_in = 1'b0;
    request = 4'b0100; request_data = 32'h00770000;
    tick();
    chk("t3 grant", grant_index, 2);
    chk("t3 flag", flag_out, 1);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t3 send ack done", done, 0);
    chk("t3 send ack busy", busy, 1);
    tick();
    chk("t3 still wait", busy, 1);
    chk("t3 still no done", done, 0);
    ack_in = 1'b1;
    tick();
    chk("t3 done", done, 4'b0100);
    chk("t3 data", data_out, 8'h77);
    tick();
    ack_in = 1'b0;
    chk("t3 done ack ignored", done, 0);
    chk("t3 idle", busy, 0);
    request = 4'b0000;

`ifdef CDC_EVENT_ARBITER_TIMEOUT_EN
    // no ack: error after the 10th WAIT cycle
    request = 4'b0010; request_data = 32'h0000BB00;
    tick();
    chk("t4 grant", grant_index, 1);
    for (int w = 1; w <= TMO; w++) begin
      tick();
      chk("t4 wait no error", error, 0);
      chk("t4 wait busy", busy, 1);
    end
    tick();
    chk("t4 error", error, 4'b0010);
    chk("t4 no done", done, 0);
    tick();
    chk("t4 error cleared", error, 0);
    chk("t4 idle", busy, 0);
    // ack on the 10th WAIT cycle wins
    tick();
    chk("t4b grant", grant_index, 1);
    for (int w = 1; w <= TMO; w++) tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t4b done", done, 4'b0010);
    chk("t4b no error", error, 0);
    request = 4'b0000;
    tick();
`else
    // without timeout, WAIT holds until ack and error stays 0
    request = 4'b0010; request_data = 32'h0000BB00;
    tick();
    chk("t4 grant", grant_index, 1);
    for (int w = 1; w <= 3 * TMO; w++) tick();
    chk("t4 still busy", busy, 1);
    chk("t4 no error", error, 0);
    chk("t4 no done", done, 0);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t4 done", done, 4'b0010);
    chk("t4 error tied", error, 0);
    request = 4'b0000;
    tick();
`endif

    // reset during WAIT abandons the transaction and resets the RR pointer
    request = 4'b0001; request_data = 32'h000000C3;
    tick();
    chk("t5 grant", grant_index, 0);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk_reset_vals("t5 reset");
    request = 4'b0000;
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t5 late ack done", done, 0);
    chk("t5 late ack busy", busy, 0);
    request = 4'b0011; request_data = 32'h0000D2C3;
    tick();
    chk("t5 first grant 0", grant_index, 0);
    chk("t5 data", data_out, 8'hC3);
    tick();
    // owner drops, index 2 rises during WAIT
    request = 4'b0100; request_data = 32'h00E1D2C3;
    tick();
    chk("t6 busy", busy, 1);
    chk("t6 data held", data_out, 8'hC3);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t6 done owner", done, 4'b0001);
    tick();
    chk("t6 idle", busy, 0);
    tick();
    chk("t6 grant 2", grant_index, 2);
    chk("t6 flag", flag_out, 1);
    chk("t6 data", data_out, 8'hE1);
    request = 4'b0000;
    tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("t6 done 2", done, 4'b0100);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
